// File: rtl/multi_writeback_pkg.sv
// -----------------------------------------------------------------------------
// multi_writeback_pkg
// Shared definitions for the multi-allocator writeback path: default widths
// and the FSM state encoding used by the top level.
// -----------------------------------------------------------------------------
package multi_writeback_pkg;

  localparam int NUM_ALLOC_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 18;
  localparam int ADDR_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FINISH  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/multi_writeback_if.sv
// -----------------------------------------------------------------------------
// multi_writeback_if
// Bundles the scheduler, allocator and output-memory signals of the
// writeback block.
//   master : scheduler/allocator side (drives round control and results)
//   slave  : the writeback block (drives acks, memory writes and status)
// Signals:
//   round_start/round_active/pixels_total/relu_en : round control
//   alloc_done/alloc_data/alloc_ack               : per-allocator results
//   out_mem_addr/out_mem_data/out_mem_en          : output memory write port
//   round_done/all_done                           : completion status
// -----------------------------------------------------------------------------
interface multi_writeback_if
  import multi_writeback_pkg::*;
#(
  parameter int NUM_ALLOCATORS = NUM_ALLOC_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int IDX_WIDTH      = 2
);

  logic                                 round_start;
  logic [IDX_WIDTH:0]                   round_active;
  logic [ADDR_WIDTH-1:0]                pixels_total;
  logic                                 relu_en;
  logic [NUM_ALLOCATORS-1:0]            alloc_done;
  logic [NUM_ALLOCATORS*DATA_WIDTH-1:0] alloc_data;
  logic [NUM_ALLOCATORS-1:0]            alloc_ack;
  logic [ADDR_WIDTH-1:0]                out_mem_addr;
  logic [DATA_WIDTH-1:0]                out_mem_data;
  logic                                 out_mem_en;
  logic                                 round_done;
  logic                                 all_done;

  modport master (
    output round_start, round_active, pixels_total, relu_en, alloc_done, alloc_data,
    input  alloc_ack, out_mem_addr, out_mem_data, out_mem_en, round_done, all_done
  );

  modport slave (
    input  round_start, round_active, pixels_total, relu_en, alloc_done, alloc_data,
    output alloc_ack, out_mem_addr, out_mem_data, out_mem_en, round_done, all_done
  );

endinterface

// File: rtl/multi_writeback_result_slot.sv
// -----------------------------------------------------------------------------
// multi_writeback_result_slot
// One holding register for one allocator's result. Captures the result when
// the allocator reports done and the slot is empty, and releases it when the
// top drains it. A drained slot stays closed until the next round begins,
// because the allocator's done level may still be high for a cycle or two
// after its ack.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   capture_en   : slot belongs to the current round and the round is collecting
//   done         : allocator result-ready level
//   data_in      : allocator result
//   drain        : top is writing this slot's result this cycle
//   round_clear  : new round accepted, reopen the slot
//   hold_data    : held result
//   hold_valid   : held result is waiting to be written
// -----------------------------------------------------------------------------
module multi_writeback_result_slot
  import multi_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture_en,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  drain,
  input  logic                  round_clear,
  output logic [DATA_WIDTH-1:0] hold_data,
  output logic                  hold_valid
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  drained_q, drained_d;
  logic                  capture;

  assign capture = capture_en && done && !valid_q && !drained_q;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    drained_d = drained_q;
    if (round_clear) begin
      valid_d   = 1'b0;
      drained_d = 1'b0;
    end else if (drain) begin
      valid_d   = 1'b0;
      drained_d = 1'b1;
    end else if (capture) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      drained_q <= drained_d;
    end
  end

  assign hold_data  = data_q;
  assign hold_valid = valid_q;

endmodule

// File: rtl/multi_writeback.sv
// -----------------------------------------------------------------------------
// multi_writeback
// Collects results from NUM_ALLOCATORS allocators and writes them to output
// memory strictly in allocator order 0..active-1 for each positioner round.
// Results that complete out of order wait in per-allocator holding slots.
// Reports a one-cycle round_done per round and a sticky all_done once
// pixels_total words have been written.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : multi_writeback_if slave (round control, allocator results,
//              output memory write port, completion status)
// -----------------------------------------------------------------------------
module multi_writeback
  import multi_writeback_pkg::*;
#(
  parameter int NUM_ALLOCATORS = NUM_ALLOC_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int IDX_WIDTH      = ($clog2(NUM_ALLOCATORS) < 1) ? 1 : $clog2(NUM_ALLOCATORS)
) (
  input  logic             clk,
  input  logic             rst,
  multi_writeback_if.slave bus
);

  localparam int CNT_W = IDX_WIDTH + 1;

  wb_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          active_q, active_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]     written_q, written_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
  logic                      mem_en_q, mem_en_d;
  logic [NUM_ALLOCATORS-1:0] ack_q, ack_d;
  logic                      round_done_q, round_done_d;
  logic                      all_done_q, all_done_d;

  logic [DATA_WIDTH-1:0]     hold_data [NUM_ALLOCATORS];
  logic [NUM_ALLOCATORS-1:0] hold_valid;
  logic [NUM_ALLOCATORS-1:0] drain_vec;
  logic                      round_clear;
  logic [DATA_WIDTH-1:0]     relu_data;
  logic                      last_slot;

  // Holding slots; only slots inside the current round may capture.
  for (genvar gi = 0; gi < NUM_ALLOCATORS; gi++) begin : g_slot
    logic in_round;
    assign in_round = (state_q == COLLECT) && (CNT_W'(gi) < active_q);

    multi_writeback_result_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .capture_en  (in_round),
      .done        (bus.alloc_done[gi]),
      .data_in     (bus.alloc_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .drain       (drain_vec[gi]),
      .round_clear (round_clear),
      .hold_data   (hold_data[gi]),
      .hold_valid  (hold_valid[gi])
    );
  end

  // Clamp negative results to zero when relu is enabled.
  always_comb begin
    relu_data = hold_data[idx_q];
    if (bus.relu_en && relu_data[DATA_WIDTH-1]) begin
      relu_data = '0;
    end
  end

  assign last_slot = (CNT_W'(idx_q) + CNT_W'(1)) == active_q;

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    written_d    = written_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_en_d     = 1'b0;
    ack_d        = '0;
    round_done_d = 1'b0;
    drain_vec    = '0;
    round_clear  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.round_start) begin
          // Counts above the allocator population are clamped so the drain
          // index can never walk past the last slot.
          if (bus.round_active > CNT_W'(NUM_ALLOCATORS)) begin
            active_d = CNT_W'(NUM_ALLOCATORS);
          end else begin
            active_d = bus.round_active;
          end
          idx_d       = '0;
          round_clear = 1'b1;
          state_d     = (bus.round_active == '0) ? FINISH : COLLECT;
        end
      end

      COLLECT: begin
        if (hold_valid[idx_q]) begin
          mem_en_d         = 1'b1;
          mem_addr_d       = addr_q;
          mem_data_d       = relu_data;
          ack_d[idx_q]     = 1'b1;
          drain_vec[idx_q] = 1'b1;
          addr_d           = addr_q + 1'b1;
          written_d        = written_q + 1'b1;
          idx_d            = idx_q + 1'b1;
          if (last_slot) begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        round_done_d = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Looks at the post-write count so all_done rises with the final write.
    all_done_d = all_done_q || (written_d == bus.pixels_total);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      active_q     <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      written_q    <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_en_q     <= 1'b0;
      ack_q        <= '0;
      round_done_q <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      written_q    <= written_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_en_q     <= mem_en_d;
      ack_q        <= ack_d;
      round_done_q <= round_done_d;
      all_done_q   <= all_done_d;
    end
  end

  assign bus.out_mem_addr = mem_addr_q;
  assign bus.out_mem_data = mem_data_q;
  assign bus.out_mem_en   = mem_en_q;
  assign bus.alloc_ack    = ack_q;
  assign bus.round_done   = round_done_q;
  assign bus.all_done     = all_done_q;

endmodule

// File: tb/tb_multi_writeback.sv
// -----------------------------------------------------------------------------
// tb_multi_writeback
// Directed bench for multi_writeback with N=4, 18-bit data, 16-bit addresses.
// A negedge monitor logs every memory write; each round's log is compared
// against hand-computed addresses, data, acks and timing.
// -----------------------------------------------------------------------------
module tb_multi_writeback;

  localparam int N  = 4;
  localparam int DW = 18;
  localparam int AW = 16;
  localparam int IW = 2;

  logic clk;
  logic rst;

  multi_writeback_if #(
    .NUM_ALLOCATORS (N),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .IDX_WIDTH      (IW)
  ) bus ();

  multi_writeback #(
    .NUM_ALLOCATORS (N),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .IDX_WIDTH      (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor
  int          cyc = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] wr_ack[$];
  logic [31:0] wr_alld[$];
  int          wr_cyc[$];
  int          rd_cyc[$];
  int          stray_ack = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.out_mem_en === 1'b1) begin
      wr_addr.push_back(32'(bus.out_mem_addr));
      wr_data.push_back(32'(bus.out_mem_data));
      wr_ack.push_back(32'(bus.alloc_ack));
      wr_alld.push_back(32'(bus.all_done));
      wr_cyc.push_back(cyc);
      $display("write cyc %0d addr %0d data %05h ack %b all_done %b",
               cyc, bus.out_mem_addr, bus.out_mem_data, bus.alloc_ack, bus.all_done);
    end else if (bus.alloc_ack !== '0) begin
      stray_ack = stray_ack + 1;
    end
    if (bus.round_done === 1'b1) rd_cyc.push_back(cyc);
  end

  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_ack.delete();
    wr_alld.delete(); wr_cyc.delete(); rd_cyc.delete();
    exp_q.delete();
    stray_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    bus.alloc_data = {d3, d2, d1, d0};
  endtask

  // Pulse round_start for one cycle; leaves the bench just after the sampling edge.
  task automatic start_round(input int active);
    bus.round_active = (IW+1)'(active);
    bus.round_start  = 1'b1;
    tick();
    bus.round_start  = 1'b0;
  endtask

  task automatic wait_round(input string tag, input int n_writes);
    int budget = 60;
    while ((wr_addr.size() < n_writes || rd_cyc.size() < 1) && budget > 0) begin
      tick();
      budget--;
    end
    check_eq({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n_writes));
    check_eq({tag, "_rdone_seen"}, 32'(rd_cyc.size()), 32'd1);
  endtask

  // Writes are back-to-back at consecutive addresses, acked with slot i's bit,
  // and round_done follows the last write by one cycle.
  task automatic check_round(input string tag, input int base);
    int n = exp_q.size();
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(base + i));
      check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], exp_q[i]);
      check_eq($sformatf("%s_ack%0d", tag, i), wr_ack[i], 32'd1 << i);
      if (i > 0) check_eq($sformatf("%s_gap%0d", tag, i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd1);
    end
    if (n > 0 && wr_cyc.size() == n && rd_cyc.size() > 0)
      check_eq({tag, "_rdone_lat"}, 32'(rd_cyc[0] - wr_cyc[n-1]), 32'd1);
    check_eq({tag, "_stray_ack"}, 32'(stray_ack), 32'd0);
  endtask

  int t0;

  initial begin
    rst              = 1'b1;
    bus.round_start  = 1'b0;
    bus.round_active = '0;
    bus.pixels_total = '0;
    bus.relu_en      = 1'b0;
    bus.alloc_done   = '0;
    bus.alloc_data   = '0;

    // Reset state, and pixels_total==0 setting all_done one cycle after release
    tick();
    check_eq("rst_mem_en",   32'(bus.out_mem_en), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.out_mem_addr), 32'd0);
    check_eq("rst_mem_data", 32'(bus.out_mem_data), 32'd0);
    check_eq("rst_ack",      32'(bus.alloc_ack), 32'd0);
    check_eq("rst_rdone",    32'(bus.round_done), 32'd0);
    check_eq("rst_alldone",  32'(bus.all_done), 32'd0);
    rst = 1'b0;
    check_eq("px0_before", 32'(bus.all_done), 32'd0);
    tick();
    check_eq("px0_after", 32'(bus.all_done), 32'd1);

    // T1: in-order completion on consecutive cycles
    bus.pixels_total = 16'd100;
    do_reset();
    set_data(18'd10, 18'd20, 18'd30, 18'd40);
    start_round(4);
    t0 = cyc;
    bus.alloc_done = 4'b0001; tick();
    bus.alloc_done = 4'b0011; tick();
    bus.alloc_done = 4'b0111; tick();
    bus.alloc_done = 4'b1111;
    exp_q = '{32'd10, 32'd20, 32'd30, 32'd40};
    wait_round("t1", 4);
    if (wr_cyc.size() > 0) check_eq("t1_latency", 32'(wr_cyc[0] - t0), 32'd3);
    check_round("t1", 0);
    bus.alloc_done = '0;
    tick();

    // T2: reverse-order completion, still written 0..3
    do_reset();
    set_data(18'd11, 18'd22, 18'd33, 18'd44);
    start_round(4);
    bus.alloc_done = 4'b1000; tick();
    bus.alloc_done = 4'b1100; tick();
    bus.alloc_done = 4'b1110; tick();
    t0 = cyc;
    bus.alloc_done = 4'b1111;
    exp_q = '{32'd11, 32'd22, 32'd33, 32'd44};
    wait_round("t2", 4);
    if (wr_cyc.size() > 0) check_eq("t2_latency", 32'(wr_cyc[0] - t0), 32'd3);
    check_round("t2", 0);
    bus.alloc_done = '0;
    tick();

    // T3: partial rounds, addresses carry over
    do_reset();
    set_data(18'd100, 18'd200, 18'd300, 18'd400);
    start_round(2);
    bus.alloc_done = 4'b1111;
    exp_q = '{32'd100, 32'd200};
    wait_round("t3a", 2);
    check_round("t3a", 0);
    repeat (3) tick();
    check_eq("t3a_no_extra", 32'(wr_addr.size()), 32'd2);
    bus.alloc_done = '0;
    tick();
    clear_mon();
    set_data(18'd5, 18'd6, 18'd300, 18'd400);
    start_round(2);
    bus.alloc_done = 4'b1111;
    exp_q = '{32'd5, 32'd6};
    wait_round("t3b", 2);
    check_round("t3b", 2);
    bus.alloc_done = '0;
    tick();

    // T4: relu clamp on and off
    do_reset();
    bus.relu_en = 1'b1;
    set_data(18'h3FFFF, 18'h00005, 18'd0, 18'd0);
    start_round(2);
    bus.alloc_done = 4'b0011;
    exp_q = '{32'h0, 32'h5};
    wait_round("t4a", 2);
    check_round("t4a", 0);
    bus.alloc_done = '0;
    tick();
    clear_mon();
    bus.relu_en = 1'b0;
    start_round(2);
    bus.alloc_done = 4'b0011;
    exp_q = '{32'h3FFFF, 32'h5};
    wait_round("t4b", 2);
    check_round("t4b", 2);
    bus.alloc_done = '0;
    tick();

    // T5: all_done on the 6th write, sticky; empty round
    bus.pixels_total = 16'd6;
    do_reset();
    set_data(18'd1, 18'd2, 18'd3, 18'd4);
    start_round(4);
    bus.alloc_done = 4'b1111;
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    wait_round("t5a", 4);
    check_round("t5a", 0);
    if (wr_alld.size() == 4) check_eq("t5a_alld_last", wr_alld[3], 32'd0);
    bus.alloc_done = '0;
    tick();
    clear_mon();
    set_data(18'd5, 18'd6, 18'd0, 18'd0);
    start_round(2);
    bus.alloc_done = 4'b0011;
    exp_q = '{32'd5, 32'd6};
    wait_round("t5b", 2);
    check_round("t5b", 4);
    if (wr_alld.size() == 2) begin
      check_eq("t5b_alld_w5", wr_alld[0], 32'd0);
      check_eq("t5b_alld_w6", wr_alld[1], 32'd1);
    end
    bus.alloc_done = '0;
    tick();
    clear_mon();
    start_round(0);
    wait_round("t5c", 0);
    check_eq("t5c_alld_sticky", 32'(bus.all_done), 32'd1);

    // T6: asynchronous reset mid-collect with two slots held
    bus.pixels_total = 16'd100;
    do_reset();
    set_data(18'd7, 18'd8, 18'd9, 18'd0);
    start_round(4);
    bus.alloc_done = 4'b0111;
    tick();
    tick();
    check_eq("t6_write_live", 32'(bus.out_mem_en), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_async_en",   32'(bus.out_mem_en), 32'd0);
    check_eq("t6_async_ack",  32'(bus.alloc_ack), 32'd0);
    check_eq("t6_async_data", 32'(bus.out_mem_data), 32'd0);
    bus.alloc_done = '0;
    tick();
    rst = 1'b0;
    clear_mon();
    tick();
    set_data(18'd50, 18'd60, 18'd0, 18'd0);
    start_round(2);
    bus.alloc_done = 4'b0011;
    exp_q = '{32'd50, 32'd60};
    wait_round("t6", 2);
    check_round("t6", 0);
    bus.alloc_done = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_writeback.md
Name: multi_writeback

Overview:
Parametrised successor to the single-allocator writeback path. Collects results from NUM_ALLOCATORS allocators and writes them to output memory in positioner order (allocator 0..active-1 per round). Replaces the scheduler-driven writeback_en with per-allocator done sourcing. Reports round and image completion to the scheduler.

Parameters:
NUM_ALLOCATORS, 4, allocators feeding this block (1..16)
DATA_WIDTH, 18, result word width
ADDR_WIDTH, 16, output address width (virtual; offset added outside)
IDX_WIDTH, 2, clog2(NUM_ALLOCATORS), minimum 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
round_start  in  1  pulse: new positioner round begins
round_active  in  IDX_WIDTH+1  allocators placed this round (0..NUM_ALLOCATORS), sampled on round_start
pixels_total  in  ADDR_WIDTH  output words for the whole image
relu_en  in  1  clamp negative results to 0
alloc_done  in  NUM_ALLOCATORS  per-allocator result-ready level
alloc_data  in  NUM_ALLOCATORS*DATA_WIDTH  packed results, allocator i at [i*DATA_WIDTH +: DATA_WIDTH]
alloc_ack  out  NUM_ALLOCATORS  one-cycle pulse: result i consumed
out_mem_addr  out  ADDR_WIDTH  write address
out_mem_data  out  DATA_WIDTH  write data
out_mem_en  out  1  write strobe
round_done  out  1  one-cycle pulse: all active results of the round written
all_done  out  1  sticky: pixels_total words written

Behaviour:
- Reset: all outputs 0; holding valid flags cleared; addr counter 0; written counter 0; state IDLE.
- States: IDLE, COLLECT, FINISH.
- IDLE: on round_start latch active=round_active, drain index=0, go COLLECT. If active==0, go FINISH directly.
- Capture: in COLLECT, for each i<active with alloc_done[i]=1 and hold_valid[i]=0, register alloc_data slice into hold[i] and set hold_valid[i]. Done on i>=active or an already-valid slot is ignored. A slot that has been drained in this round is not recaptured until the next round_start.
- Drain: in COLLECT, if hold_valid[idx]: next edge drives out_mem_en=1, out_mem_data=hold[idx] (relu applied: if relu_en and MSB set, 0), out_mem_addr=addr counter; alloc_ack[idx]=1 same cycle; clear hold_valid[idx]; addr counter +1 (wraps mod 2^ADDR_WIDTH); idx +1. One write max per cycle.
- Latency: done sampled at edge N -> write strobe at edge N+1 when that slot is next in order. Out-of-order completions wait in holding registers.
- After writing idx==active-1: go FINISH.
- FINISH: round_done=1 for one cycle, return IDLE.
- all_done: set on the cycle written counter reaches pixels_total. Stays set until rst. Further writes are still performed and not blocked. With pixels_total==0, all_done sets one cycle after reset release.
- round_start outside IDLE is ignored. The scheduler must not pulse it before round_done.
- relu_en and pixels_total are read live. Changing them mid-image is unsupported.
- rst mid-round: immediate return to reset state; pending results are discarded; no ack is issued.

Decomposition:
- Shared package (accel_pkg): DATA_WIDTH, ADDR_WIDTH defaults and the state encoding localparams IDLE/COLLECT/FINISH.
- Natural sub-module: result_slot (one holding register + valid flag + capture/clear logic), instantiated NUM_ALLOCATORS times via generate.
- Top holds the FSM, drain index, address and written counters, and the relu mux.

Test Plan:
- N=4, active=4, done asserted 0,1,2,3 on consecutive cycles with data 10,20,30,40 -> writes addr 0..3, data 10,20,30,40, one per cycle. round_done 1 cycle after last write.
- N=4, active=4, done in order 3,2,1,0 -> writes still in order 0,1,2,3 at addr 0..3. Each alloc_ack fires on its own write cycle.
- Partial round: active=2, done on all 4 -> only 2 writes. Allocators 2,3 never acked. round_done pulses. Next round_start: addresses continue at 2.
- relu_en=1, data 18'h3FFFF and 18'h00005 -> written 0 and 5. With relu_en=0 -> 18'h3FFFF and 5.
- pixels_total=6, two rounds of active=4 then 2 -> all_done rises on the cycle of the 6th write and stays high. active=0 round -> round_done next cycle with no write.
- rst asserted asynchronously mid-COLLECT with two slots held -> outputs 0 immediately. Following round writes start at addr 0.
